// File: rtl/cpu_control_rtype_if.sv
// Observation bus carrying the combinational ALU result of the single-cycle R-type core.
interface cpu_control_rtype_if;
    logic [31:0] resultado;

    modport master (output resultado);
    modport slave  (input  resultado);
endinterface

// File: rtl/cpu_control_rtype.sv
// Single-cycle MIPS datapath for R-type instructions: PC, instruction memory,
// register bank, control decode and ALU, with the ALU result exported.

module cpu_instmem (
    input  logic [5:0]  addr_i,
    output logic [31:0] data_o
);
    // Contents are preloaded externally; no reset or write port.
    logic [31:0] instBank [0:63];

    assign data_o = instBank[addr_i];
endmodule

module cpu_regbank (
    input  logic        clk_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] registerBank [0:31];

    // Register 0 reads as zero regardless of what the array holds.
    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : registerBank[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : registerBank[raddr_b_i];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            registerBank[waddr_i] <= wdata_i;
        end
    end
endmodule

module cpu_alu (
    input  logic [31:0]           a_i,
    input  logic [31:0]           b_i,
    input  logic [4:0]            shamt_i,
    input  logic [5:0]            funct_i,
    cpu_control_rtype_if.master   res_o
);
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    always_comb begin
        res_o.resultado = '0;
        case (funct_i)
            FN_ADD:  res_o.resultado = a_i + b_i;
            FN_SUB:  res_o.resultado = a_i - b_i;
            FN_AND:  res_o.resultado = a_i & b_i;
            FN_OR:   res_o.resultado = a_i | b_i;
            FN_XOR:  res_o.resultado = a_i ^ b_i;
            FN_NOR:  res_o.resultado = ~(a_i | b_i);
            FN_SLT:  res_o.resultado = {31'd0, ($signed(a_i) < $signed(b_i))};
            FN_SLL:  res_o.resultado = b_i << shamt_i;
            FN_SRL:  res_o.resultado = b_i >> shamt_i;
            default: res_o.resultado = '0;
        endcase
    end
endmodule

module cpu_control_rtype (
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);
    // Power-up value lets the core run without an initial reset pulse.
    logic [31:0] pc_q = '0;
    logic [31:0] pc_d;

    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic        reg_write;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    cpu_control_rtype_if alu_if ();

    cpu_instmem IM (
        .addr_i (pc_q[7:2]),
        .data_o (instr)
    );

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];

    // Only op 0 writes back; every other opcode behaves as a NOP.
    assign reg_write = (op == 6'd0);

    cpu_regbank BR (
        .clk_i     (clk_CPU),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (reg_write),
        .waddr_i   (rd),
        .wdata_i   (alu_if.resultado)
    );

    cpu_alu ALU (
        .a_i     (rdata_a),
        .b_i     (rdata_b),
        .shamt_i (shamt),
        .funct_i (funct),
        .res_o   (alu_if.master)
    );

    assign resultado = alu_if.resultado;

    assign pc_d = pc_q + 32'd4;

    always_ff @(posedge clk_CPU) begin
        if (rst_CPU) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: tb/tb_cpu_control_rtype.sv
// Scoreboard bench for cpu_control_rtype: directed program, queued expectations,
// negedge monitor comparing resultado, PC and register contents.
module tb_cpu_control_rtype;
  logic clk = 1'b0;
  logic rst;
  logic done = 1'b0;

  cpu_control_rtype_if obs_if ();

  cpu_control_rtype dut (
    .clk_CPU   (clk),
    .rst_CPU   (rst),
    .resultado (obs_if.resultado)
  );

  always #5 clk = ~clk;

  typedef enum int { K_RES, K_PC, K_REG } kind_t;
  typedef struct {
    kind_t       kind;
    int          idx;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] NOP = 32'h8C00_0000;

  function automatic void push(kind_t k, int idx, logic [31:0] v, string tag);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    e.tag  = tag;
    exp_q.push_back(e);
  endfunction

  // Monitor: drains every queued expectation at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RES:   act = obs_if.resultado;
        K_PC:    act = dut.pc_q;
        default: act = dut.BR.registerBank[e.idx];
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h, expected %h", e.tag, act, e.val);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: program did not complete within the wait limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] res2 [0:14];

  initial begin
    rst = 1'b1;

    for (int unsigned i = 0; i < 64; i++) dut.IM.instBank[i] = NOP;
    dut.IM.instBank[0]  = 32'h0022_1820; // add $3,$1,$2
    dut.IM.instBank[1]  = 32'h0061_3025; // or  $6,$3,$1
    dut.IM.instBank[2]  = 32'h8C22_4020; // op 0x23, funct add, rd field 8
    dut.IM.instBank[3]  = 32'h0041_2022; // sub $4,$2,$1
    dut.IM.instBank[4]  = 32'h0081_282A; // slt $5,$4,$1
    dut.IM.instBank[5]  = 32'h0024_282A; // slt $5,$1,$4
    dut.IM.instBank[6]  = 32'h0022_0020; // add $0,$1,$2
    dut.IM.instBank[7]  = 32'h0002_3820; // add $7,$0,$2
    dut.IM.instBank[8]  = 32'h0022_4824; // and $9,$1,$2
    dut.IM.instBank[9]  = 32'h0022_5026; // xor $10,$1,$2
    dut.IM.instBank[10] = 32'h0022_5827; // nor $11,$1,$2
    dut.IM.instBank[11] = 32'h0002_6100; // sll $12,$2,4
    dut.IM.instBank[12] = 32'h0004_6842; // srl $13,$4,1
    dut.IM.instBank[13] = 32'h0022_703F; // funct 0x3F -> 0, rd 14

    for (int unsigned i = 0; i < 32; i++) dut.BR.registerBank[i] <= 32'd0;
    dut.BR.registerBank[1]  <= 32'd5;
    dut.BR.registerBank[2]  <= 32'd3;
    dut.BR.registerBank[8]  <= 32'h0000_AAAA;
    dut.BR.registerBank[14] <= 32'h0000_DEAD;

    res2[0]  = 32'd8;         res2[1]  = 32'd13;        res2[2]  = 32'd8;
    res2[3]  = 32'hFFFF_FFFE; res2[4]  = 32'd1;         res2[5]  = 32'd0;
    res2[6]  = 32'd8;         res2[7]  = 32'd3;         res2[8]  = 32'd1;
    res2[9]  = 32'd6;         res2[10] = 32'hFFFF_FFF8; res2[11] = 32'd48;
    res2[12] = 32'h7FFF_FFFF; res2[13] = 32'd0;         res2[14] = 32'd0;

    // Reset edge coincides with add $3: PC -> 0 and the write still lands.
    step();
    rst = 1'b0;
    total++;
    if (dut.pc_q !== 32'd0 || obs_if.resultado !== 32'd8) begin
      bad++;
      $display("FAIL reset_state: pc=%h resultado=%h, expected pc=0 resultado=8",
               dut.pc_q, obs_if.resultado);
    end
    push(K_PC, 0, 32'd0, "reset_pc");
    push(K_RES, 0, 32'd8, "add_res");
    push(K_REG, 3, 32'd8, "reset_edge_write_r3");

    step();
    push(K_PC, 0, 32'd4, "pc_after_add");
    push(K_RES, 0, 32'd13, "or_dependent_res");

    step();
    push(K_PC, 0, 32'd8, "pc_slot2");
    push(K_RES, 0, 32'd8, "nonr_res");
    push(K_REG, 6, 32'd13, "r6_written");

    step();
    push(K_PC, 0, 32'd12, "pc_after_nonr");
    push(K_RES, 0, 32'hFFFF_FFFE, "sub_neg_res");
    push(K_REG, 8, 32'h0000_AAAA, "nonr_no_write_r8");
    rst = 1'b1;

    step();
    rst = 1'b0;
    push(K_PC, 0, 32'd0, "midrun_reset_pc");
    push(K_RES, 0, 32'd8, "midrun_reset_res");
    push(K_REG, 4, 32'hFFFF_FFFE, "r4_written_on_reset");
    push(K_REG, 1, 32'd5, "r1_retained");
    push(K_REG, 2, 32'd3, "r2_retained");

    for (int unsigned i = 1; i < 15; i++) begin
      step();
      push(K_PC, 0, 32'(4 * i), $sformatf("pc_slot%0d", i));
      push(K_RES, 0, res2[i], $sformatf("res_slot%0d", i));
      case (i)
        5: push(K_REG, 5, 32'd1, "slt_true_r5");
        6: push(K_REG, 5, 32'd0, "slt_false_r5");
        7: push(K_REG, 0, 32'd0, "r0_unwritten");
        8: push(K_REG, 7, 32'd3, "r7_from_r0");
        14: begin
          push(K_REG, 9,  32'd1,         "and_r9");
          push(K_REG, 10, 32'd6,         "xor_r10");
          push(K_REG, 11, 32'hFFFF_FFF8, "nor_r11");
          push(K_REG, 12, 32'd48,        "sll_r12");
          push(K_REG, 13, 32'h7FFF_FFFF, "srl_r13");
          push(K_REG, 14, 32'd0,         "bad_funct_r14");
        end
        default: ;
      endcase
    end

    // Run the NOP tail until the word index wraps back to slot 0.
    for (int unsigned pc = 60; pc <= 252; pc += 4) begin
      step();
      push(K_PC, 0, 32'(pc), "pc_nop_tail");
      push(K_RES, 0, 32'd0, "res_nop_tail");
    end

    step();
    push(K_PC, 0, 32'd256, "pc_wrap");
    push(K_RES, 0, 32'd8, "res_wrap_slot0");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $finish;
  end
endmodule
